serial_2scomp_rx: RTL and testbench
===================================

Name: serial_2scomp_rx

Overview:
- Receive-side counterpart of the team's serial two's-complement encoder.
- Takes an LSB-first serial bit stream framed into WORD_W-bit words, negates each word on the fly with the pass-until-first-1-then-invert rule, and deserialises it.
- Presents each result as a parallel word through a one-entry valid/ready output buffer, with overflow and overrun flags.
- Sits between the serial link and parallel datapath logic.

Parameters:
- WORD_W, 4, bits per serial word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- xin  input  1  serial data bit, LSB of each word first.
- xin_valid  input  1  qualifies xin; bit consumed on a clk edge with xin_valid=1.
- yout  output  1  combinational negated bit for the current xin: xin in PASS, ~xin in INV. Don't-care when xin_valid=0.
- dout  output  WORD_W  last completed negated word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- dout_ovf  output  WORD_W==1?1:1  set with dout when the input word was -2^(WORD_W-1), i.e. the negation is not representable.
- overrun  output  1  one-cycle pulse when a completed word is dropped.

Behaviour:
- Reset is synchronous, active-high, and overrides everything, including mid-word. Reset state:
  - bit_cnt=0, FSM=PASS, shift/raw registers=0.
  - dout=0, dout_valid=0, dout_ovf=0, overrun=0.
- FSM states, updated only on edges with xin_valid=1:
  - PASS: yout=xin; go to INV if xin=1, else stay.
  - INV: yout=~xin; stay.
  - Last bit of a word (bit_cnt==WORD_W-1): FSM returns to PASS and bit_cnt to 0, regardless of xin.
- bit_cnt increments on each valid bit. It wraps WORD_W-1 -> 0. Gaps (xin_valid=0) freeze bit_cnt, FSM and shift registers.
- Shift register: right shift with yout inserted at the MSB, so after WORD_W bits the word is {yout_last, sr[WORD_W-1:1]}. A raw shift register captures xin the same way.
- Completion: occurs on the edge that consumes bit WORD_W-1.
  - Output buffer empty, or dout_ready=1 that cycle: dout is loaded and dout_valid=1 at that edge. Latency is 0 cycles after the last bit's edge. Simultaneous consume and load yields the new word with dout_valid staying 1.
  - Output buffer full and dout_ready=0: the new word is dropped, dout and dout_ovf are held, and overrun=1 for the next cycle only.
- dout_ovf = (raw word == 1 followed by WORD_W-1 zeros). Input 0 gives dout=0 with dout_ovf=0.
- Handshake: dout_valid is cleared on an edge with dout_valid=1 and dout_ready=1 when no new completion occurs on that edge. dout and dout_ovf are stable while dout_valid=1 and dout_ready=0. dout_ready is ignored while dout_valid=0.
- Arithmetic is modulo 2^WORD_W. The negation of the most-negative value equals itself and is flagged by dout_ovf.

Optional Feature:
- Macro: SERIAL_2SCOMP_RX_FRAME_EN.
- When defined:
  - Adds input port sof (1 bit), valid only together with xin_valid.
  - sof=1 forces the current bit to be treated as bit 0: bit_cnt is treated as 0, the FSM as PASS, and the partially assembled word is discarded without an overrun pulse.
  - Adds output frame_err, a one-cycle pulse when sof=1 arrives while bit_cnt!=0.
- When undefined: no sof or frame_err ports; framing comes purely from bit_cnt after reset.

Decomposition:
- Shared package/header serial_2scomp_pkg holds:
  - FSM state encodings PASS=1'b0, INV=1'b1.
  - Default WORD_W constant.
- One sub-module is natural: serial_negate_cell.
  - Contents: the two-state PASS/INV Mealy cell.
  - Inputs: clk, reset, bit_in, bit_valid, word_last.
  - Output: bit_out.
  - The encoder-side work reuses it.
- The counter, shift registers and output buffer stay in the top.

Test Plan (WORD_W=4):
- Bits 1,1,0,0 (raw 3), dout_ready=1 -> yout 1,0,1,1; dout=4'hD, dout_valid=1 on the last bit edge, dout_ovf=0.
- Bits 0,0,0,0, then 0,0,0,1 (raw 8) -> dout=0 with ovf=0, then dout=4'h8 with dout_ovf=1.
- Raw 5 (bits 1,0,1,0) with xin_valid low for 3 cycles between bits 2 and 3 -> dout=4'hB; bit_cnt/FSM held during the gaps.
- dout_ready=0, two back-to-back words 1 then 2 -> dout stays 4'hF, overrun pulses once; then dout_ready=1 -> dout_valid drops next edge.
- Reset asserted after 2 bits of a word, then a full word 6 (bits 0,1,1,0) -> dout=4'hA, no stale bits, all outputs 0 during reset.
- FRAME_EN build: sof at bit_cnt=2 followed by word 1 -> frame_err pulse, dout=4'hF, no overrun.

Source files
------------

// File: rtl/serial_2scomp_pkg.sv
// serial_2scomp_pkg: shared PASS/INV state encoding and default word width
// for the serial two's-complement encoder/receiver pair.
package serial_2scomp_pkg;
    typedef enum logic {PASS = 1'b0, INV = 1'b1} neg_state_e;
    localparam int WORD_W_DEFAULT = 4;
endpackage

// File: rtl/serial_negate_cell.sv
// serial_negate_cell: two-state Mealy cell that passes bits until the first 1
// of a word, then inverts the rest; restart treats the current bit as bit 0.
module serial_negate_cell
    import serial_2scomp_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic word_last,
    input  logic restart,
    output logic bit_out
);
    neg_state_e state, state_nx, cur;

    always_ff @(posedge clk) begin
        if (reset) state <= PASS;
        else       state <= state_nx;
    end

    always_comb begin
        cur      = restart ? PASS : state;
        bit_out  = (cur == INV) ? ~bit_in : bit_in;
        state_nx = state;
        if (bit_valid)
            state_nx = word_last ? PASS : ((cur == INV || bit_in) ? INV : PASS);
    end
endmodule

// File: rtl/serial_2scomp_rx.sv
// serial_2scomp_rx: LSB-first serial negator/deserialiser with one-entry output
// buffer; define SERIAL_2SCOMP_RX_FRAME_EN to add sof resync and frame_err.
module serial_2scomp_rx
    import serial_2scomp_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              xin,
    input  logic              xin_valid,
`ifdef SERIAL_2SCOMP_RX_FRAME_EN
    input  logic              sof,
    output logic              frame_err,
`endif
    output logic              yout,
    output logic [WORD_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_ovf,
    output logic              overrun
);
    localparam int CW = $clog2(WORD_W);

    logic [CW-1:0]     bit_cnt, cnt_eff;
    logic [WORD_W-2:0] sr, raw;
    logic [WORD_W-1:0] word, raw_word;
    logic              restart, word_last, done, ovf_new, load;

`ifdef SERIAL_2SCOMP_RX_FRAME_EN
    assign restart = xin_valid & sof;
`else
    assign restart = 1'b0;
`endif

    serial_negate_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (xin),
        .bit_valid(xin_valid),
        .word_last(word_last),
        .restart  (restart),
        .bit_out  (yout)
    );

    // A resync bit starts a new word; stale low bits shift out before completion.
    always_comb begin
        cnt_eff   = restart ? '0 : bit_cnt;
        word_last = cnt_eff == CW'(WORD_W - 1);
        done      = xin_valid & word_last;
        word      = {yout, sr};
        raw_word  = {xin, raw};
        ovf_new   = raw_word == {1'b1, {(WORD_W-1){1'b0}}};
        load      = done & (~dout_valid | dout_ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= '0;
            sr      <= '0;
            raw     <= '0;
        end else if (xin_valid) begin
            bit_cnt <= word_last ? '0 : cnt_eff + CW'(1);
            sr      <= word[WORD_W-1:1];
            raw     <= raw_word[WORD_W-1:1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ovf   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun    <= done & ~load;
            dout_valid <= load | (dout_valid & ~dout_ready);
            if (load) begin
                dout     <= word;
                dout_ovf <= ovf_new;
            end
        end
    end

`ifdef SERIAL_2SCOMP_RX_FRAME_EN
    always_ff @(posedge clk) begin
        if (reset) frame_err <= 1'b0;
        else       frame_err <= restart & (bit_cnt != '0);
    end
`endif
endmodule

// File: tb/tb_serial_2scomp_rx.sv
// tb_serial_2scomp_rx: directed and randomized checks against an arithmetic negation model.
module tb_serial_2scomp_rx;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset, xin, xin_valid, dout_ready, sof;
    logic yout, dout_valid, dout_ovf, overrun, frame_err;
    logic [W-1:0] dout;

    int n_cmp = 0;
    int n_err = 0;

    int         m_idx, m_raw;
    bit         m_full, m_ovf, m_overrun, m_ferr, m_yout;
    logic [W-1:0] m_dout;
    logic       obs_yout;

    always #5 clk = ~clk;

    serial_2scomp_rx #(.WORD_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .xin       (xin),
        .xin_valid (xin_valid),
`ifdef SERIAL_2SCOMP_RX_FRAME_EN
        .sof       (sof),
        .frame_err (frame_err),
`endif
        .yout      (yout),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_ovf  (dout_ovf),
        .overrun   (overrun)
    );

`ifndef SERIAL_2SCOMP_RX_FRAME_EN
    assign frame_err = 1'b0;
`endif

    // Drive one cycle, sample yout before the edge, advance the model, sample after the edge.
    task automatic step(input logic x, input logic v, input logic r, input logic s, input logic rs);
        bit done;
        reset = rs; xin = x; xin_valid = v; dout_ready = r; sof = s;
        #1 obs_yout = yout;
        if (rs) begin
            m_idx = 0; m_raw = 0; m_full = 0; m_dout = '0; m_ovf = 0; m_overrun = 0; m_ferr = 0;
        end else begin
            m_overrun = 0;
            m_ferr = 0;
            done = 0;
            if (v) begin
                if (s) begin
                    m_ferr = (m_idx != 0);
                    m_idx = 0;
                    m_raw = 0;
                end
                m_raw = m_raw | (int'(x) << m_idx);
                m_yout = bit'(((-m_raw) >> m_idx) & 1);
                done = (m_idx == W - 1);
            end
            if (done) begin
                if (!m_full || r) begin
                    m_full = 1;
                    m_dout = W'(-m_raw);
                    m_ovf = (m_raw == (1 << (W - 1)));
                end else m_overrun = 1;
                m_idx = 0;
                m_raw = 0;
            end else begin
                if (v) m_idx++;
                if (m_full && r) m_full = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(1, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_dout got %h exp 0", dout); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        n_cmp++; if (dout_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", dout_ovf); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    endtask

    task automatic test_basic();
        logic [3:0] bits = 4'b0011;
        logic [3:0] ey   = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            step(bits[i], 1, 1, 0, 0);
            n_cmp++; if (obs_yout !== ey[i]) begin n_err++; $display("FAIL basic_yout%0d got %b exp %b", i, obs_yout, ey[i]); end
            if (i < 3) begin
                n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid%0d got %b exp 0", i, dout_valid); end
            end
        end
        n_cmp++; if (dout !== 4'hD) begin n_err++; $display("FAIL basic_dout got %h exp d", dout); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", dout_valid); end
        n_cmp++; if (dout_ovf !== 1'b0) begin n_err++; $display("FAIL basic_ovf got %b exp 0", dout_ovf); end
        step(0, 0, 1, 0, 0);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL basic_consume got %b exp 0", dout_valid); end
    endtask

    task automatic test_ovf();
        logic [3:0] raws [2] = '{4'h0, 4'h8};
        logic [3:0] ed   [2] = '{4'h0, 4'h8};
        logic       eo   [2] = '{1'b0, 1'b1};
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 4; i++) step(raws[w][i], 1, 1, 0, 0);
            n_cmp++; if (dout !== ed[w]) begin n_err++; $display("FAIL ovf_dout%0d got %h exp %h", w, dout, ed[w]); end
            n_cmp++; if (dout_ovf !== eo[w]) begin n_err++; $display("FAIL ovf_flag%0d got %b exp %b", w, dout_ovf, eo[w]); end
            n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid%0d got %b exp 1", w, dout_valid); end
        end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_gap();
        logic [3:0] ey = 4'b1011;
        step(1, 1, 1, 0, 0);
        n_cmp++; if (obs_yout !== ey[0]) begin n_err++; $display("FAIL gap_yout0 got %b exp %b", obs_yout, ey[0]); end
        step(0, 1, 1, 0, 0);
        n_cmp++; if (obs_yout !== ey[1]) begin n_err++; $display("FAIL gap_yout1 got %b exp %b", obs_yout, ey[1]); end
        step(1, 1, 1, 0, 0);
        n_cmp++; if (obs_yout !== ey[2]) begin n_err++; $display("FAIL gap_yout2 got %b exp %b", obs_yout, ey[2]); end
        for (int g = 0; g < 3; g++) begin
            step($urandom_range(0, 1), 0, 1, 0, 0);
            n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL gap_idle_valid%0d got %b exp 0", g, dout_valid); end
        end
        step(0, 1, 1, 0, 0);
        n_cmp++; if (obs_yout !== ey[3]) begin n_err++; $display("FAIL gap_yout3 got %b exp %b", obs_yout, ey[3]); end
        n_cmp++; if (dout !== 4'hB) begin n_err++; $display("FAIL gap_dout got %h exp b", dout); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL gap_valid got %b exp 1", dout_valid); end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b0010_0001;
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(bits[i], 1, 0, 0, 0);
            pulses += int'(overrun);
            if (i == 3) begin
                n_cmp++; if (dout !== 4'hF) begin n_err++; $display("FAIL b2b_first_dout got %h exp f", dout); end
            end
        end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL b2b_overrun got %b exp 1", overrun); end
        n_cmp++; if (dout !== 4'hF) begin n_err++; $display("FAIL b2b_held_dout got %h exp f", dout); end
        step(0, 0, 0, 0, 0);
        pulses += int'(overrun);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_pulse_len got %b exp 0", overrun); end
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 4'hF) begin n_err++; $display("FAIL b2b_hold got %b/%h exp 1/f", dout_valid, dout); end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL b2b_pulse_count got %0d exp 1", pulses); end
        step(0, 0, 1, 0, 0);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", dout_valid); end
    endtask

    task automatic test_reset_midword();
        logic [3:0] bits = 4'b0110;
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        n_cmp++; if ({dout, dout_valid, dout_ovf, overrun} !== '0) begin n_err++; $display("FAIL rstmid_outs got %h/%b/%b/%b exp 0", dout, dout_valid, dout_ovf, overrun); end
        for (int i = 0; i < 4; i++) step(bits[i], 1, 1, 0, 0);
        n_cmp++; if (dout !== 4'hA) begin n_err++; $display("FAIL rstmid_dout got %h exp a", dout); end
        n_cmp++; if (dout_valid !== 1'b1 || dout_ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_flags got %b/%b exp 1/0", dout_valid, dout_ovf); end
        step(0, 0, 1, 0, 0);
    endtask

`ifdef SERIAL_2SCOMP_RX_FRAME_EN
    task automatic test_frame();
        int ovr = 0;
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        ovr += int'(overrun);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL frame_err_pulse got %b exp 1", frame_err); end
        step(0, 1, 1, 0, 0);
        ovr += int'(overrun);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL frame_err_len got %b exp 0", frame_err); end
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        ovr += int'(overrun);
        n_cmp++; if (dout !== 4'hF || dout_valid !== 1'b1) begin n_err++; $display("FAIL frame_dout got %h/%b exp f/1", dout, dout_valid); end
        n_cmp++; if (ovr != 0) begin n_err++; $display("FAIL frame_overrun got %0d exp 0", ovr); end
        step(0, 0, 1, 0, 0);
    endtask
`endif

    task automatic test_random();
        logic x, v, r, s, rs;
        for (int n = 0; n < 600; n++) begin
            rs = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            x  = 1'($urandom_range(0, 1));
            r  = ($urandom_range(0, 2) != 0);
`ifdef SERIAL_2SCOMP_RX_FRAME_EN
            s  = v && ($urandom_range(0, 15) == 0);
`else
            s  = 1'b0;
`endif
            step(x, v, r, s, rs);
            if (v && !rs) begin
                n_cmp++; if (obs_yout !== m_yout) begin n_err++; $display("FAIL rnd_yout@%0d got %b exp %b", n, obs_yout, m_yout); end
            end
            n_cmp++; if (dout_valid !== m_full) begin n_err++; $display("FAIL rnd_valid@%0d got %b exp %b", n, dout_valid, m_full); end
            n_cmp++; if (dout !== m_dout) begin n_err++; $display("FAIL rnd_dout@%0d got %h exp %h", n, dout, m_dout); end
            n_cmp++; if (dout_ovf !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d got %b exp %b", n, dout_ovf, m_ovf); end
            n_cmp++; if (overrun !== m_overrun) begin n_err++; $display("FAIL rnd_overrun@%0d got %b exp %b", n, overrun, m_overrun); end
`ifdef SERIAL_2SCOMP_RX_FRAME_EN
            n_cmp++; if (frame_err !== m_ferr) begin n_err++; $display("FAIL rnd_frame_err@%0d got %b exp %b", n, frame_err, m_ferr); end
`endif
        end
    endtask

    initial begin
        m_yout = 0;
        test_reset();
        test_basic();
        test_ovf();
        test_gap();
        test_back_to_back();
        test_reset_midword();
`ifdef SERIAL_2SCOMP_RX_FRAME_EN
        test_frame();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
